pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage rv32i core. It combines load-use and branch hazard detection, EX-stage operand forwarding select, and a multi-cycle data-memory wait sequencer into one set of per-stage stall/flush controls. It also holds a memory-timeout watchdog with a sticky error state and saturating stall/flush performance counters. It sits beside the pipeline registers and drives their enable and clear inputs.

---
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the rv32i pipeline registers and the hazard controller.
// The controller takes the slave side; the pipeline (or a testbench) takes the master side.
interface pipe_hazard_ctrl_if #(
   parameter int REG_WIDTH = 5,
   parameter int CNT_W     = 16
);
   logic                 is_loadE;
   logic [REG_WIDTH-1:0] Rs1D;
   logic [REG_WIDTH-1:0] Rs2D;
   logic [REG_WIDTH-1:0] Rs1E;
   logic [REG_WIDTH-1:0] Rs2E;
   logic [REG_WIDTH-1:0] RdE;
   logic [REG_WIDTH-1:0] RdM;
   logic [REG_WIDTH-1:0] RdW;
   logic                 regwriteM;
   logic                 regwriteW;
   logic                 PCSrcE;
   logic                 dmem_req;
   logic                 dmem_ready;

   logic                 stallF;
   logic                 stallD;
   logic                 stallE;
   logic                 stallM;
   logic                 flushD;
   logic                 flushE;
   logic                 flushW;
   logic [1:0]           forwardAE;
   logic [1:0]           forwardBE;
   logic                 mem_err;
   logic [CNT_W-1:0]     stall_cnt;
   logic [CNT_W-1:0]     flush_cnt;

   modport master (
      output is_loadE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             regwriteM, regwriteW, PCSrcE, dmem_req, dmem_ready,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
             forwardAE, forwardBE, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  is_loadE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             regwriteM, regwriteW, PCSrcE, dmem_req, dmem_ready,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
             forwardAE, forwardBE, mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage rv32i pipeline, with a
// data-memory wait sequencer, sticky timeout watchdog and saturating perf counters.
module pipe_hazard_ctrl #(
   parameter int REG_WIDTH = 5,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_ERR
   } state_e;

   state_e           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             lwStall;
   logic             memStall;

   // M-stage result is newer than W-stage, so it wins when both match.
   function automatic logic [1:0] fwdSel(input logic [REG_WIDTH-1:0] rs,
                                         input logic [REG_WIDTH-1:0] rdM,
                                         input logic [REG_WIDTH-1:0] rdW,
                                         input logic                 rwM,
                                         input logic                 rwW);
      if (rwM && (rdM != '0) && (rdM == rs)) return 2'b10;
      if (rwW && (rdW != '0) && (rdW == rs)) return 2'b01;
      return 2'b00;
   endfunction

   assign bus.forwardAE = fwdSel(bus.Rs1E, bus.RdM, bus.RdW, bus.regwriteM, bus.regwriteW);
   assign bus.forwardBE = fwdSel(bus.Rs2E, bus.RdM, bus.RdW, bus.regwriteM, bus.regwriteW);

   assign lwStall  = bus.is_loadE && (bus.RdE != '0) &&
                     ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
   assign memStall = bus.dmem_req && !bus.dmem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      bus.stallF = 1'b0;
      bus.stallD = 1'b0;
      bus.stallE = 1'b0;
      bus.stallM = 1'b0;
      bus.flushD = 1'b0;
      bus.flushE = 1'b0;
      bus.flushW = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (memStall) begin
               state_d    = ST_WAIT;
               wait_cnt_d = WCW'(1);
            end
         end
         ST_WAIT: begin
            if (!memStall) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
               state_d   = ST_ERR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         ST_ERR: begin
         end
         default: state_d = ST_RUN;
      endcase

      // A frozen E stage makes hazard decisions stale, so memory waits mask them.
      if ((state_q == ST_ERR) || memStall) begin
         bus.stallF = 1'b1;
         bus.stallD = 1'b1;
         bus.stallE = 1'b1;
         bus.stallM = 1'b1;
         bus.flushW = 1'b1;
      end else begin
         bus.stallF = lwStall;
         bus.stallD = lwStall;
         bus.flushD = bus.PCSrcE;
         bus.flushE = lwStall || bus.PCSrcE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (bus.stallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bus.flushD && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.mem_err   = mem_err_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: constant vector table, hand-written
// memory-wait/timeout/saturation sequences, and random stimulus against a model.
module tb_pipe_hazard_ctrl;

   localparam int RW   = 5;
   localparam int TO   = 16;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   typedef struct {
      logic          isLoad;
      logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
      logic          rwM, rwW, pcSrc, req, ready;
   } in_t;

   // exp packs {stallF,stallD,stallE,stallM,flushD,flushE,flushW,forwardAE,forwardBE}
   typedef struct {
      in_t         in;
      logic [10:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   bit mErr;
   int mRun;
   int mStallCnt;
   int mFlushCnt;

   vec_t tbl[13];
   in_t  idle;

   pipe_hazard_ctrl_if #(.REG_WIDTH(RW), .CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(.REG_WIDTH(RW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input in_t s);
      bus.is_loadE   = s.isLoad;
      bus.Rs1D       = s.rs1D;
      bus.Rs2D       = s.rs2D;
      bus.Rs1E       = s.rs1E;
      bus.Rs2E       = s.rs2E;
      bus.RdE        = s.rdE;
      bus.RdM        = s.rdM;
      bus.RdW        = s.rdW;
      bus.regwriteM  = s.rwM;
      bus.regwriteW  = s.rwW;
      bus.PCSrcE     = s.pcSrc;
      bus.dmem_req   = s.req;
      bus.dmem_ready = s.ready;
   endtask

   function automatic vec_t mk(input logic isLoad, input int rs1D, input int rs2D, input int rdE,
                               input logic pc, input logic rwM, input int rdM, input logic rwW,
                               input int rdW, input int rs1E, input int rs2E, input logic [10:0] exp);
      vec_t v;
      v.in.isLoad = isLoad;
      v.in.rs1D   = RW'(rs1D);
      v.in.rs2D   = RW'(rs2D);
      v.in.rdE    = RW'(rdE);
      v.in.pcSrc  = pc;
      v.in.rwM    = rwM;
      v.in.rdM    = RW'(rdM);
      v.in.rwW    = rwW;
      v.in.rdW    = RW'(rdW);
      v.in.rs1E   = RW'(rs1E);
      v.in.rs2E   = RW'(rs2E);
      v.in.req    = 1'b0;
      v.in.ready  = 1'b0;
      v.exp       = exp;
      return v;
   endfunction

   function automatic logic [1:0] modelFwd(input logic [RW-1:0] rs, input in_t s);
      if (s.rwM && s.rdM != 0 && s.rdM == rs) return 2'b10;
      if (s.rwW && s.rdW != 0 && s.rdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [10:0] modelOut(input in_t s);
      bit lw, ms;
      logic [6:0] ctl;
      lw = s.isLoad && s.rdE != 0 && (s.rs1D == s.rdE || s.rs2D == s.rdE);
      ms = s.req && !s.ready;
      if (mErr || ms) ctl = 7'b1111_001;
      else            ctl = {lw, lw, 1'b0, 1'b0, s.pcSrc, lw | s.pcSrc, 1'b0};
      return {ctl, modelFwd(s.rs1E, s), modelFwd(s.rs2E, s)};
   endfunction

   function automatic logic [10:0] dutOut();
      return {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushD, bus.flushE,
              bus.flushW, bus.forwardAE, bus.forwardBE};
   endfunction

   task automatic modelReset();
      mErr      = 1'b0;
      mRun      = 0;
      mStallCnt = 0;
      mFlushCnt = 0;
   endtask

   task automatic modelStep(input in_t s, input logic [10:0] e);
      if (e[10]) mStallCnt = (mStallCnt < CMAX) ? mStallCnt + 1 : CMAX;
      if (e[6])  mFlushCnt = (mFlushCnt < CMAX) ? mFlushCnt + 1 : CMAX;
      if (!mErr) begin
         if (s.req && !s.ready) begin
            mRun++;
            if (mRun >= TO) mErr = 1'b1;
         end else begin
            mRun = 0;
         end
      end
   endtask

   // Entered and left at one time unit after a rising edge.
   task automatic cycle(input in_t s, input string tag, input bit hasExp, input logic [10:0] tExp);
      logic [10:0] e;
      applyStimulus(s);
      #1;
      e = modelOut(s);
      checkOutput({tag, " ctrl"}, 32'(dutOut()), 32'(e));
      if (hasExp) checkOutput({tag, " ctrl/table"}, 32'(dutOut()), 32'(tExp));
      @(posedge clk);
      modelStep(s, e);
      #1;
      checkOutput({tag, " mem_err"}, 32'(bus.mem_err), 32'(mErr));
      checkOutput({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(mStallCnt));
      checkOutput({tag, " flush_cnt"}, 32'(bus.flush_cnt), 32'(mFlushCnt));
   endtask

   // Reset is raised mid-cycle so its asynchronous effect is visible before any edge.
   task automatic doReset();
      applyStimulus(idle);
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("reset mem_err", 32'(bus.mem_err), 32'd0);
      checkOutput("reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
      checkOutput("reset flush_cnt", 32'(bus.flush_cnt), 32'd0);
      checkOutput("reset ctrl", 32'(dutOut()), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      in_t s;
      errors = 0;
      checks = 0;
      idle   = '{default: '0};
      modelReset();
      rst = 1'b1;
      applyStimulus(idle);

      tbl[0]  = mk(1, 2, 3, 2, 0, 0, 0, 0, 0, 0, 0, 11'b1100_010_00_00);
      tbl[1]  = mk(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_000_00_00);
      tbl[2]  = mk(1, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 11'b1100_010_00_00);
      tbl[3]  = mk(1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 11'b0000_000_00_00);
      tbl[4]  = mk(0, 2, 3, 2, 0, 0, 0, 0, 0, 0, 0, 11'b0000_000_00_00);
      tbl[5]  = mk(1, 2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 11'b1100_110_00_00);
      tbl[6]  = mk(0, 2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 11'b0000_110_00_00);
      tbl[7]  = mk(0, 0, 0, 0, 0, 1, 5, 1, 5, 5, 7, 11'b0000_000_10_00);
      tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 5, 5, 7, 11'b0000_000_01_00);
      tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 5, 5, 7, 11'b0000_000_00_00);
      tbl[10] = mk(0, 0, 0, 0, 0, 1, 7, 1, 5, 5, 7, 11'b0000_000_01_10);
      tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 11'b0000_000_00_00);
      tbl[12] = mk(1, 2, 3, 2, 0, 0, 0, 0, 0, 0, 0, 11'b1100_010_00_00);
      tbl[12].in.req   = 1'b1;
      tbl[12].in.ready = 1'b1;

      #3;
      checkOutput("por mem_err", 32'(bus.mem_err), 32'd0);
      checkOutput("por stall_cnt", 32'(bus.stall_cnt), 32'd0);
      checkOutput("por flush_cnt", 32'(bus.flush_cnt), 32'd0);
      checkOutput("por ctrl", 32'(dutOut()), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 13; i++) cycle(tbl[i].in, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);

      // Branch together with load-use: flush_cnt steps once per cycle.
      doReset();
      for (int i = 0; i < 3; i++) cycle(tbl[5].in, $sformatf("brlw%0d", i), 1'b1, tbl[5].exp);
      checkOutput("brlw flush_cnt", 32'(bus.flush_cnt), 32'd3);

      // Three-cycle memory wait under a taken branch, then completion.
      doReset();
      s = idle;
      s.req   = 1'b1;
      s.pcSrc = 1'b1;
      for (int i = 0; i < 3; i++) cycle(s, $sformatf("mwait%0d", i), 1'b1, 11'b1111_001_00_00);
      s.ready = 1'b1;
      cycle(s, "mdone", 1'b1, 11'b0000_110_00_00);
      checkOutput("mdone stall_cnt", 32'(bus.stall_cnt), 32'd3);
      checkOutput("mdone flush_cnt", 32'(bus.flush_cnt), 32'd1);
      cycle(idle, "midle", 1'b1, 11'b0000_000_00_00);

      // Watchdog fires after exactly TIMEOUT stalled cycles and stays sticky.
      doReset();
      s = idle;
      s.req = 1'b1;
      for (int i = 0; i < TO - 1; i++) cycle(s, $sformatf("to%0d", i), 1'b0, '0);
      checkOutput("to pre-err", 32'(bus.mem_err), 32'd0);
      cycle(s, "to last", 1'b0, '0);
      checkOutput("to err", 32'(bus.mem_err), 32'd1);
      s.ready = 1'b1;
      s.pcSrc = 1'b1;
      for (int i = 0; i < 3; i++) cycle(s, $sformatf("err%0d", i), 1'b1, 11'b1111_001_00_00);
      checkOutput("err sticky", 32'(bus.mem_err), 32'd1);
      doReset();

      // Reset in the middle of a wait must also clear the wait count.
      s = idle;
      s.req = 1'b1;
      for (int i = 0; i < 5; i++) cycle(s, $sformatf("pre%0d", i), 1'b0, '0);
      doReset();
      for (int i = 0; i < TO - 1; i++) cycle(s, $sformatf("post%0d", i), 1'b0, '0);
      checkOutput("midwait no err", 32'(bus.mem_err), 32'd0);
      cycle(idle, "post idle", 1'b1, 11'b0000_000_00_00);

      // Saturation of the narrow stall counter.
      doReset();
      for (int i = 0; i < 20; i++) cycle(tbl[0].in, $sformatf("sat%0d", i), 1'b0, '0);
      checkOutput("sat stall_cnt", 32'(bus.stall_cnt), 32'd15);

      // Random traffic with a forced long wait window to reach the error state.
      doReset();
      for (int i = 0; i < 400; i++) begin
         s.isLoad = 1'($urandom_range(0, 1));
         s.rs1D   = RW'($urandom_range(0, 3));
         s.rs2D   = RW'($urandom_range(0, 3));
         s.rs1E   = RW'($urandom_range(0, 3));
         s.rs2E   = RW'($urandom_range(0, 3));
         s.rdE    = RW'($urandom_range(0, 3));
         s.rdM    = RW'($urandom_range(0, 3));
         s.rdW    = RW'($urandom_range(0, 3));
         s.rwM    = 1'($urandom_range(0, 1));
         s.rwW    = 1'($urandom_range(0, 1));
         s.pcSrc  = ($urandom_range(0, 3) == 0);
         s.req    = 1'($urandom_range(0, 1));
         s.ready  = ($urandom_range(0, 9) < 7);
         if (i >= 200 && i < 220) begin
            s.req   = 1'b1;
            s.ready = 1'b0;
         end
         cycle(s, $sformatf("rnd%0d", i), 1'b0, '0);
         if (i != 199 && $urandom_range(0, 99) < 2) doReset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
